// File: rtl/chain_pipe_engine_if.sv
// Handshake and status bundle for chain_pipe_engine.
//   in_valid/in_ready/in/mode : input word handshake; mode is sampled with in on accept
//   out_valid/out_ready/out   : output word handshake
//   clr                       : synchronous clear of chk and cnt
//   chk/cnt                   : running XOR checksum and saturating word count
// The slave modport is the engine side; the master modport is the source/sink side.
interface chain_pipe_engine_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             clr;
  logic [WIDTH-1:0] chk;
  logic [CNT_W-1:0] cnt;

  modport slave (
    input  in_valid, in, mode, out_ready, clr,
    output in_ready, out_valid, out, chk, cnt
  );

  modport master (
    output in_valid, in, mode, out_ready, clr,
    input  in_ready, out_valid, out, chk, cnt
  );
endinterface

// File: rtl/chain_pipe_engine.sv
// chain_pipe_engine: CHANNEL-stage word pipeline with valid/ready at both ends.
// Each stage applies a transform chosen by the word's own 2-bit mode tag
// (PASS, MIX = rotl1 ^ (i+1), ADD = + (i+1), INV = ~), the tag travelling with
// the word. The whole pipe shifts together or holds together (global
// back-pressure); bubbles are never squeezed out. Output handshakes feed a
// running XOR checksum and a saturating counter, both cleared by clr.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : chain_pipe_engine_if.slave (in/out handshakes, mode, clr, chk, cnt)
module chain_pipe_engine #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned CHANNEL = 60,
  parameter int unsigned CNT_W   = 16
) (
  input logic                clk,
  input logic                rst,
  chain_pipe_engine_if.slave bus
);

  logic             adv;
  logic             fire;

  logic             vld_q  [CHANNEL];
  logic             vld_d  [CHANNEL];
  logic [WIDTH-1:0] data_q [CHANNEL];
  logic [WIDTH-1:0] data_d [CHANNEL];
  logic [1:0]       tag_q  [CHANNEL];
  logic [1:0]       tag_d  [CHANNEL];

  logic [WIDTH-1:0] chk_q, chk_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Transform applied by stage idx (0-based) to the word entering it.
  function automatic logic [WIDTH-1:0] xform(input logic [WIDTH-1:0] x,
                                             input logic [1:0]       m,
                                             input int unsigned      idx);
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] res;
    step = WIDTH'(idx + 1);
    unique case (m)
      2'd0:    res = x;
      2'd1:    res = {x[WIDTH-2:0], x[WIDTH-1]} ^ step;
      2'd2:    res = x + step;
      default: res = ~x;
    endcase
    return res;
  endfunction

  // Only a valid word stuck at the last stage can stall the pipe.
  assign adv  = !(vld_q[CHANNEL-1] && !bus.out_ready);
  assign fire = vld_q[CHANNEL-1] && bus.out_ready;

  always_comb begin
    for (int unsigned i = 0; i < CHANNEL; i++) begin
      vld_d[i]  = vld_q[i];
      data_d[i] = data_q[i];
      tag_d[i]  = tag_q[i];
    end
    if (adv) begin
      vld_d[0]  = bus.in_valid;
      tag_d[0]  = bus.mode;
      data_d[0] = xform(bus.in, bus.mode, 0);
      for (int unsigned i = 1; i < CHANNEL; i++) begin
        vld_d[i]  = vld_q[i-1];
        tag_d[i]  = tag_q[i-1];
        data_d[i] = xform(data_q[i-1], tag_q[i-1], i);
      end
    end
  end

  // clr takes priority over a same-cycle output handshake.
  always_comb begin
    chk_d = chk_q;
    cnt_d = cnt_q;
    if (bus.clr) begin
      chk_d = '0;
      cnt_d = '0;
    end else if (fire) begin
      chk_d = chk_q ^ data_q[CHANNEL-1];
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < CHANNEL; i++) begin
        vld_q[i]  <= 1'b0;
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      chk_q <= '0;
      cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < CHANNEL; i++) begin
        vld_q[i]  <= vld_d[i];
        data_q[i] <= data_d[i];
        tag_q[i]  <= tag_d[i];
      end
      chk_q <= chk_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_q[CHANNEL-1];
  assign bus.out       = data_q[CHANNEL-1];
  assign bus.chk       = chk_q;
  assign bus.cnt       = cnt_q;

endmodule
